// File: rtl/load_store_unit.sv
// Load/store unit: decodes load/store requests and runs one bus access per request.
// It handles lane steering, sign/zero extension, alignment and funct3 faults, and a bus-ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        misaligned,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [2:0]  f3_q, f3_d;
  logic        store_q, store_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        req, is_load, legal, aligned, accept, timeout;
  logic [31:0] lane_w, load_val;

  // Request decode; a simultaneous read and write is treated as a load.
  always_comb begin
    req     = mem_rd_en | mem_wr_en;
    is_load = mem_rd_en;
    if (is_load) legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
    else         legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept  = (state_q == IDLE) && req && legal && aligned;
    timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    lane_w = bus_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane_w[7]}}, lane_w[7:0]};
      3'b100:  load_val = {24'd0, lane_w[7:0]};
      3'b001:  load_val = {{16{lane_w[15]}}, lane_w[15:0]};
      3'b101:  load_val = {16'd0, lane_w[15:0]};
      default: load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // An ack in the cycle the counter hits its limit completes normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS: begin
        if (bus_ack)      state_d = store_q ? IDLE : RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    store_d   = store_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    mis_d     = 1'b0;
    fault_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!legal)        fault_d = 1'b1;
          else if (!aligned) mis_d   = 1'b1;
          else begin
            addr_d  = addr;
            wdata_d = wr_data;
            f3_d    = funct3;
            store_d = ~is_load;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          if (!store_q) rd_data_d = load_val;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (timeout) fault_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      store_q   <= store_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      mis_q     <= mis_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    bus_req      = (state_q == ACCESS);
    bus_we       = bus_req && store_q;
    bus_addr     = bus_req ? {addr_q[31:2], 2'b00} : '0;
    bus_be       = '0;
    bus_wdata    = '0;
    if (bus_req) begin
      bus_be = '1;
      if (store_q) begin
        case (f3_q[1:0])
          2'b00: begin
            bus_be    = 4'b0001 << addr_q[1:0];
            bus_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            bus_be    = 4'b0011 << {addr_q[1], 1'b0};
            bus_wdata = {2{wdata_q[15:0]}};
          end
          default: bus_wdata = wdata_q;
        endcase
      end
    end
    stall        = accept || (state_q == ACCESS);
    rd_valid     = (state_q == RESP);
    rd_data      = rd_data_q;
    misaligned   = mis_q;
    access_fault = fault_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference model
// covering faults, lane steering, extension, timeout and mid-access reset.
module tb_load_store_unit;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  funct3;
  logic [31:0] addr, wr_data;
  logic        stall, rd_valid, misaligned, access_fault;
  logic [31:0] rd_data;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] last_rd = '0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .funct3(funct3), .addr(addr), .wr_data(wr_data), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .misaligned(misaligned),
    .access_fault(access_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_legal(input bit ld, input logic [2:0] f);
    if (ld) return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return f inside {3'd0, 3'd1, 3'd2};
  endfunction

  function automatic int unsigned m_size(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input bit ld, input logic [2:0] f, input logic [31:0] a);
    if (ld || m_size(f) == 4) return 4'hF;
    if (m_size(f) == 1) return 4'(1 << (a % 4));
    return 4'(3 << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
    if (m_size(f) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (m_size(f) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (a % 4));
    if (m_size(f) == 1) begin
      v = v & 32'hFF;
      if (!f[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (m_size(f) == 2) begin
      v = v & 32'hFFFF;
      if (!f[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else v = rdata;
    return v;
  endfunction

  // Issues one request and plays the bus slave; dly >= TMO never acks.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int unsigned dly, input logic [31:0] rdata);
    bit ld, lg, al, done;
    logic [31:0] exp_rd;
    ld = rd;
    lg = m_legal(ld, f);
    al = (a % m_size(f)) == 0;
    mem_rd_en = rd; mem_wr_en = wr; funct3 = f; addr = a; wr_data = wd;
    #1;
    check("stall_req", 32'(stall), 32'(lg && al));
    tick();
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    addr = $urandom; wr_data = $urandom; funct3 = 3'($urandom);
    #1;
    if (!lg) begin
      check("fault_illegal", 32'(access_fault), 32'd1);
      check("mis_illegal", 32'(misaligned), 32'd0);
      check("req_illegal", 32'(bus_req), 32'd0);
      tick();
      check("fault_pulse_end", 32'(access_fault), 32'd0);
    end else if (!al) begin
      check("mis_pulse", 32'(misaligned), 32'd1);
      check("fault_mis", 32'(access_fault), 32'd0);
      check("req_mis", 32'(bus_req), 32'd0);
      check("stall_mis", 32'(stall), 32'd0);
      tick();
      check("mis_pulse_end", 32'(misaligned), 32'd0);
    end else begin
      done = 1'b0;
      for (int unsigned k = 0; k < TMO; k++) begin
        check("bus_req", 32'(bus_req), 32'd1);
        check("stall_acc", 32'(stall), 32'd1);
        check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
        check("bus_be", 32'(bus_be), 32'(m_be(ld, f, a)));
        check("bus_we", 32'(bus_we), 32'(!ld));
        if (!ld) check("bus_wdata", bus_wdata, m_wdata(f, wd));
        if (k == dly) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
        tick();
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        #1;
        if (k == dly) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        check("tmo_req", 32'(bus_req), 32'd0);
        check("tmo_fault", 32'(access_fault), 32'd1);
        check("tmo_valid", 32'(rd_valid), 32'd0);
        tick();
        check("tmo_fault_end", 32'(access_fault), 32'd0);
        check("tmo_valid_end", 32'(rd_valid), 32'd0);
      end else if (ld) begin
        exp_rd = m_load(f, a, rdata);
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", rd_data, exp_rd);
        check("stall_resp", 32'(stall), 32'd0);
        check("req_resp", 32'(bus_req), 32'd0);
        last_rd = exp_rd;
        tick();
        check("rd_valid_end", 32'(rd_valid), 32'd0);
      end else begin
        check("st_valid", 32'(rd_valid), 32'd0);
        check("st_req_end", 32'(bus_req), 32'd0);
        check("st_fault", 32'(access_fault), 32'd0);
      end
    end
    check("rd_data_hold", rd_data, last_rd);
  endtask

  initial begin
    rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; funct3 = '0;
    addr = '0; wr_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    rst = 1'b0;
    tick();

    run_txn(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_FF7F);
    run_txn(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 1, 32'h0);
    run_txn(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    run_txn(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'hBEEF_0000);
    run_txn(1, 0, 3'b010, 32'h300, 32'h0, 100, 32'h0);
    run_txn(1, 0, 3'b010, 32'h300, 32'h0, TMO - 1, 32'hCAFE_F00D);
    run_txn(0, 1, 3'b100, 32'h10, 32'h55, 0, 32'h0);
    run_txn(1, 0, 3'b110, 32'h11, 32'h0, 0, 32'h0);
    run_txn(1, 0, 3'b011, 32'h13, 32'h0, 0, 32'h0);
    run_txn(1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h1111_2222);
    run_txn(1, 0, 3'b010, 32'h4, 32'h0, 0, 32'h3333_4444);
    run_txn(1, 1, 3'b100, 32'h11, 32'h9, 0, 32'h0000_9A00);

    // Reset landing in the third access cycle, followed by a late ack.
    mem_rd_en = 1'b1; funct3 = 3'b010; addr = 32'h40;
    tick();
    mem_rd_en = 1'b0;
    tick();
    check("rstmid_req2", 32'(bus_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    check("rstmid_req", 32'(bus_req), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_rd_data", rd_data, 32'd0);
    check("rstmid_we", 32'(bus_we), 32'd0);
    check("rstmid_wdata", bus_wdata, 32'd0);
    last_rd = '0;
    tick();
    bus_ack = 1'b0;
    check("rstmid_valid", 32'(rd_valid), 32'd0);
    check("rstmid_req_after", 32'(bus_req), 32'd0);

    for (int i = 0; i < 150; i++) begin
      bit rd, wr;
      logic [2:0] f;
      int unsigned dly;
      rd = 1'($urandom);
      wr = rd ? ($urandom % 4 == 0) : 1'b1;
      if ($urandom % 4 == 0) f = 3'($urandom);
      else begin
        case ($urandom % 5)
          0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; default: f = 3'd5;
        endcase
      end
      case ($urandom % 10)
        0:       dly = TMO + ($urandom % 3);
        1:       dly = TMO - 1;
        default: dly = $urandom % 6;
      endcase
      if ($urandom % 5 == 0) begin
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_valid", 32'(rd_valid), 32'd0);
        check("idle_ack_req", 32'(bus_req), 32'd0);
      end
      run_txn(rd, wr, f, $urandom, $urandom, dly, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles spent waiting for bus_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port mem_rd_en, input, 1, meaning a load is requested (from the control decoder).
REQ-005 SHALL have port mem_wr_en, input, 1, meaning a store is requested.
REQ-006 SHALL have port funct3, input, 3, the access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have ports addr (input, 32, the ALU-computed byte address) and wr_data (input, 32, the rs2 store data).
REQ-008 SHALL have ports stall (output, 1, hold the pipeline), rd_data (output, 32, the extended load result) and rd_valid (output, 1, rd_data valid).
REQ-009 SHALL have ports misaligned (output, 1, alignment fault pulse) and access_fault (output, 1, illegal funct3 or timeout pulse).
REQ-010 SHALL have bus ports bus_req (out, 1), bus_we (out, 1), bus_addr (out, 32), bus_be (out, 4), bus_wdata (out, 32), bus_ack (in, 1) and bus_rdata (in, 32).

Function
REQ-011 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-012 In IDLE with mem_rd_en or mem_wr_en high, SHALL decode the request in the same cycle.
- Both high: treat as a load.
REQ-013 Illegal funct3 SHALL pulse access_fault for 1 cycle (the cycle after the request) and SHALL NOT start a bus access.
- Illegal for loads: 011, 110, 111.
- Illegal for stores: any value other than 000, 001, 010.
REQ-014 Misaligned requests SHALL pulse misaligned for 1 cycle, stay in IDLE and issue no bus access.
- H/HU with addr[0]=1.
- W with addr[1:0]!=0.
REQ-015 A legal, aligned request SHALL latch addr, funct3, wr_data and the direction, then enter ACCESS on the next edge.
REQ-016 In ACCESS, SHALL hold bus_req=1 with stable bus fields until bus_ack=1.
- bus_addr = {addr[31:2], 2'b00}; bus_we = 1 for stores.
REQ-017 Store lanes SHALL be driven as follows.
- bus_be: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111.
- bus_wdata: byte replicated ×4 (SB); halfword replicated ×2 (SH); the full word (SW).
REQ-018 Loads SHALL drive bus_be=1111.
REQ-019 On bus_ack in ACCESS, a store SHALL return to IDLE and a load SHALL capture the extracted lane into rd_data and enter RESP.
- Lane: bus_rdata byte/halfword selected by addr[1:0].
- Extension: sign-extend for B/H, zero-extend for BU/HU.
REQ-020 RESP SHALL last exactly 1 cycle with rd_valid=1, then return to IDLE.
- rd_data SHALL hold its value until the next load capture.
REQ-021 stall SHALL be combinational.
- stall = (IDLE & (mem_rd_en|mem_wr_en) & legal & aligned) | ACCESS.
- stall = 0 in RESP.
- Load latency: request cycle to rd_valid = 2 + ack wait cycles; ack in the first ACCESS cycle gives rd_valid 2 cycles after the request.
REQ-022 A timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
- When it reaches TIMEOUT_CYCLES: bus_req drops, access_fault pulses 1 cycle, FSM returns to IDLE, rd_valid stays 0.
- bus_ack in the same cycle the count reaches the limit SHALL win (normal completion).
REQ-023 bus_ack outside ACCESS SHALL be ignored.
REQ-024 The 32-bit addr SHALL be used unmodified apart from clearing bits [1:0]; no address wrap handling is required.
REQ-025 The misaligned and access_fault pulses SHALL never both be 1 in the same cycle.
- Illegal funct3 takes priority over misalignment.

Reset
REQ-026 rst=1 at any edge, including mid-ACCESS, SHALL force IDLE and drop bus_req the next cycle with no completion.
- Reset values: stall=0, rd_valid=0, rd_data=0, misaligned=0, access_fault=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, counter=0.

Verification
REQ-027 LB at addr 0x103, bus_rdata=0x80FF_FF7F, ack after 2 cycles -> bus_addr=0x100, bus_be=1111, rd_data=0xFFFF_FF80, single rd_valid pulse.
REQ-028 SH at addr 0x202, wr_data=0x1234_ABCD -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1, stall high until ack, no rd_valid.
REQ-029 LW at addr 0x101 -> misaligned=1 for 1 cycle, bus_req stays 0, stall=0; LHU at 0x102 with bus_rdata=0xBEEF_0000 -> rd_data=0x0000_BEEF.
REQ-030 Load with bus_ack held 0 and TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then access_fault pulse, IDLE, rd_valid never asserted.
REQ-031 rst asserted in the 3rd ACCESS cycle, then ack arrives -> bus_req=0 on the next cycle, ack ignored, all outputs at reset values.
REQ-032 Store with funct3=100 -> access_fault pulse, no bus_req; back-to-back LW 0x0, LW 0x4 with immediate acks -> two rd_valid pulses with correct words.
